// File: rtl/decode_regfile.sv
// SEQ Y86-64 decode/write-back stage: derives register IDs from the fetched
// instruction, reads operands combinationally and commits valE/valM at the clock edge.
module decode_regfile #(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_03F8,
  parameter int          NREG       = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  input  logic [3:0]  dbg_addr,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] dbg_data
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'h4;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // ifun only matters upstream (execute resolves cnd); kept on the port for visibility.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_CMOV: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      I_IRMOV: dstE = rB;
      I_RMMOV: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOV: begin
        srcB = rB;
        dstM = rA;
      end
      I_OP: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP;
        dstE = RSP;
      end
      I_RET: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
      end
      I_PUSH: begin
        srcA = rA;
        srcB = RSP;
        dstE = RSP;
      end
      I_POP: begin
        srcA = RSP;
        srcB = RSP;
        dstE = RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // 16-entry read view; entry F (and anything beyond NREG) reads as zero.
  logic [63:0] rd_view [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_reg
    if (gi < NREG) begin : g_live
      localparam logic [3:0]  ID      = 4'(gi);
      localparam logic [63:0] RST_VAL = (gi == 4) ? STACK_INIT : 64'h0;
      logic [63:0] reg_q;
      logic [63:0] reg_d;

      // M port is applied last so it wins a same-register collision (popq %rsp).
      always_comb begin
        reg_d = reg_q;
        if (wb_en) begin
          if (dstE == ID) reg_d = valE;
          if (dstM == ID) reg_d = valM;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= RST_VAL;
        else        reg_q <= reg_d;
      end

      assign rd_view[gi] = reg_q;
    end else begin : g_none
      assign rd_view[gi] = 64'h0;
    end
  end

  assign valA     = rd_view[srcA];
  assign valB     = rd_view[srcB];
  assign dbg_data = rd_view[dbg_addr];

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: decode IDs, operand reads, write-back
// priority, wb_en gating and asynchronous reset behaviour.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun, rA, rB, dbg_addr;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_data;

  int checks = 0;
  int errors = 0;

  decode_regfile dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en), .dbg_addr(dbg_addr),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] id, input logic [63:0] exp, input string tag);
    dbg_addr = id;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic set_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                           input logic [3:0] b, input logic c, input logic [63:0] e,
                           input logic [63:0] m, input logic we);
    icode = ic; ifun = fn; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = we;
    #1;
    $display("step t=%0t icode=%h ifun=%h rA=%h rB=%h cnd=%b wb_en=%b -> srcA=%h srcB=%h dstE=%h dstM=%h",
             $time, ic, fn, a, b, c, we, srcA, srcB, dstE, dstM);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    icode = 4'h0; ifun = 4'h0; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; wb_en = 1'b0; dbg_addr = 4'h0;
    #12 rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 15; i++)
      rd(4'(i), (i == 4) ? 64'h3F8 : 64'h0, $sformatf("reset_R%0d", i));
    rd(4'hF, 64'h0, "reset_RNONE");
    check("reset_valA", valA, 64'h0);
    check("reset_valB", valB, 64'h0);
    check("halt_srcA", {60'h0, srcA}, 64'hF);
    check("halt_dstE", {60'h0, dstE}, 64'hF);

    // irmovq into R2, then OPq reading it back
    tick();
    set_instr(4'h3, 4'h0, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'h0, 1'b1);
    check("irmov_dstE", {60'h0, dstE}, 64'h2);
    check("irmov_srcA", {60'h0, srcA}, 64'hF);
    tick();
    rd(4'h2, 64'hDEAD_BEEF, "irmov_R2");
    set_instr(4'h6, 4'h0, 4'h2, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
    check("op_srcA", {60'h0, srcA}, 64'h2);
    check("op_srcB", {60'h0, srcB}, 64'h3);
    check("op_dstE", {60'h0, dstE}, 64'h3);
    check("op_valA", valA, 64'hDEAD_BEEF);
    check("op_valB", valB, 64'h0);

    // cmov gating by cnd
    set_instr(4'h2, 4'h3, 4'h1, 4'h5, 1'b0, 64'h7, 64'h0, 1'b1);
    check("cmov_nc_dstE", {60'h0, dstE}, 64'hF);
    check("cmov_nc_srcA", {60'h0, srcA}, 64'h1);
    tick();
    rd(4'h5, 64'h0, "cmov_nc_R5");
    set_instr(4'h2, 4'h3, 4'h1, 4'h5, 1'b1, 64'h7, 64'h0, 1'b1);
    check("cmov_c_dstE", {60'h0, dstE}, 64'h5);
    tick();
    rd(4'h5, 64'h7, "cmov_c_R5");

    // popq %rsp: valM beats valE; reads are pre-edge values
    set_instr(4'hB, 4'h0, 4'h4, 4'hF, 1'b0, 64'h400, 64'h1234, 1'b1);
    check("pop_srcA", {60'h0, srcA}, 64'h4);
    check("pop_srcB", {60'h0, srcB}, 64'h4);
    check("pop_dstE", {60'h0, dstE}, 64'h4);
    check("pop_dstM", {60'h0, dstM}, 64'h4);
    check("pop_valA_pre", valA, 64'h3F8);
    tick();
    rd(4'h4, 64'h1234, "pop_R4");

    // pushq decode
    set_instr(4'hA, 4'h0, 4'h2, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    check("push_srcA", {60'h0, srcA}, 64'h2);
    check("push_srcB", {60'h0, srcB}, 64'h4);
    check("push_dstM", {60'h0, dstM}, 64'hF);

    // wb_en=0 blocks writes
    set_instr(4'h3, 4'h0, 4'hF, 4'h6, 1'b0, 64'h9, 64'h0, 1'b0);
    tick();
    rd(4'h6, 64'h0, "wben0_R6");

    // Invalid icode: all IDs F, no write
    set_instr(4'hC, 4'h0, 4'h1, 4'h2, 1'b1, 64'h55, 64'h66, 1'b1);
    check("inv_srcA", {60'h0, srcA}, 64'hF);
    check("inv_srcB", {60'h0, srcB}, 64'hF);
    check("inv_dstE", {60'h0, dstE}, 64'hF);
    check("inv_dstM", {60'h0, dstM}, 64'hF);
    tick();
    rd(4'h1, 64'h0, "inv_R1");
    rd(4'h2, 64'hDEAD_BEEF, "inv_R2");

    // mrmovq: full 64-bit valM into rA
    set_instr(4'h5, 4'h0, 4'h8, 4'h9, 1'b0, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b1);
    check("mrmov_srcA", {60'h0, srcA}, 64'hF);
    check("mrmov_srcB", {60'h0, srcB}, 64'h9);
    check("mrmov_dstM", {60'h0, dstM}, 64'h8);
    tick();
    rd(4'h8, 64'hFEDC_BA98_7654_3210, "mrmov_R8");

    // Async reset mid-cycle drops the pending write
    set_instr(4'h3, 4'h0, 4'hF, 4'h7, 1'b0, 64'h5, 64'h0, 1'b1);
    tick();
    rd(4'h7, 64'h5, "pre_rst_R7");
    valE = 64'h6;
    #3 rst_n = 1'b0;
    rd(4'h7, 64'h0, "async_rst_R7");
    rd(4'h4, 64'h3F8, "async_rst_R4");
    tick();
    rd(4'h7, 64'h0, "rst_edge_R7");
    rd(4'h2, 64'h0, "rst_edge_R2");
    #2 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
